// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder for a CPU load/store port.
// Faults, store writes and load reads all resolve at the accept edge.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0] CNT_INIT =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          misal;
  logic          fault;
  logic [31:0]   off;
  logic [AW-1:0] widx;
  logic [31:0]   word;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [31:0]   ldval;
  logic [3:0]    be;
  logic [31:0]   wd;

  assign accept = (state_q == S_IDLE) && req_valid && !reset;
  assign off    = req_addr - BASE_ADDR;
  assign widx   = off[AW+1:2];
  assign word   = mem_q[widx];
  assign lb     = word[{req_addr[1:0], 3'b000} +: 8];
  assign lh     = req_addr[1] ? word[31:16] : word[15:0];
  assign fault  = misal || ({1'b0, off} >= LIMIT);

  always_comb begin
    misal = 1'b0;
    unique case (req_size)
      2'd0: misal = 1'b0;
      2'd1: misal = req_addr[0];
      2'd2: misal = (req_addr[1:0] != 2'b00);
      default: misal = 1'b1;
    endcase
  end

  always_comb begin
    ldval = word;
    be    = 4'b1111;
    wd    = req_wdata;
    unique case (req_size)
      2'd0: begin
        ldval = {{24{lb[7] & ~req_unsigned}}, lb};
        be    = 4'b0001 << req_addr[1:0];
        wd    = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        ldval = {{16{lh[15] & ~req_unsigned}}, lh};
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wd    = {2{req_wdata[15:0]}};
      end
      default: begin
        ldval = word;
        be    = 4'b1111;
        wd    = req_wdata;
      end
    endcase
  end

  // storage is deliberately outside reset
  always_ff @(posedge clk) begin
    if (accept && req_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
          cnt_d   = CNT_INIT;
          rdata_d = (fault || req_we) ? 32'd0 : ldval;
          err_d   = fault;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit storage words.
REQ-002 Parameter LATENCY, default 2: cycles from request accept edge to resp_valid high; legal range 1..15.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  CPU presents a load/store request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
REQ-011 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-012 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-013 resp_valid  output  1  response available.
REQ-014 resp_ready  input  1  CPU accepts the response.
REQ-015 resp_rdata  output  32  load result; 0 for stores and errors.
REQ-016 resp_err  output  1  request faulted (misaligned, out of range, or illegal size).

Function
REQ-017 FSM states SHALL be IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE, so at most one request is outstanding.
REQ-018 Accept SHALL occur on a rising edge where state = IDLE and req_valid = 1; all req_* fields are latched at that edge.
REQ-019 On accept, next state SHALL be RESP if LATENCY = 1, else WAIT with a 4-bit counter loaded to LATENCY-2.
REQ-020 In WAIT, the counter SHALL decrement each cycle; when it equals 0, next state SHALL be RESP.
REQ-021 resp_valid SHALL be 1 exactly when state = RESP, i.e. first high LATENCY cycles after the accept edge.
REQ-022 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until resp_ready = 1; that edge returns to IDLE.
REQ-023 A new request SHALL NOT be accepted on the same edge as a response handshake; earliest re-accept is the following edge.
REQ-024 Error SHALL be flagged when: req_size = 3; half with addr[0] = 1; word with addr[1:0] != 0; or (addr - BASE_ADDR) >= DEPTH_WORDS*4 (unsigned 32-bit subtraction, so addresses below BASE_ADDR wrap and fault).
REQ-025 An erroring request SHALL perform no memory write; it responds with resp_err = 1, resp_rdata = 0.
REQ-026 A legal store SHALL write memory at the accept edge: byte writes lane addr[1:0] from wdata[7:0]; half writes lanes {addr[1],0}, +1 from wdata[15:0]; word writes all lanes; other lanes unchanged.
REQ-027 A legal load SHALL read the word at the accept edge and select lane(s) by addr[1:0]; byte/half results are sign- or zero-extended per req_unsigned.
REQ-028 Store responses SHALL carry resp_rdata = 0, resp_err = 0.
REQ-029 Word index SHALL be (addr - BASE_ADDR) >> 2.

Reset
REQ-030 While reset = 1 at an edge: state -> IDLE, counter -> 0, resp_valid -> 0, resp_err -> 0, resp_rdata -> 0; req_ready = 1 from the following cycle.
REQ-031 Reset mid-transaction SHALL discard the pending response; a store already committed at its accept edge remains written.
REQ-032 Memory contents SHALL NOT be affected by reset.
REQ-033 reset has priority over accept and response handshake in the same cycle.

Verification
REQ-034 Store word 0xDEADBEEF at 0x10, then load word 0x10 with resp_ready = 1 -> resp_rdata = 0xDEADBEEF, resp_err = 0, resp_valid high exactly 2 cycles after each accept.
REQ-035 After REQ-034, load byte 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half 0x10 signed -> 0xFFFFBEEF.
REQ-036 Store byte 0x55 at 0x11, then load word 0x10 -> 0xDEAD55EF.
REQ-037 Load half at 0x11, load word at 0x12, size 3 at 0x10, word load at 0x1000 (DEPTH_WORDS = 1024) -> each resp_err = 1, resp_rdata = 0; a following word load at 0x10 still returns the prior value.
REQ-038 Hold resp_ready = 0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stay constant and req_ready = 0 throughout; a new req_valid is not accepted until the edge after the handshake.
REQ-039 Assert reset for 1 cycle while in WAIT after a store of 0x12345678 at 0x20 -> no response appears; a later load of 0x20 returns 0x12345678.
